register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
Parameters:
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of each register and each data port in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning width of each register address.
REQ-003 SHALL have parameter NUM_REGS, default 32 (2**ADDR_WIDTH), meaning number of architectural registers, x0..x(NUM_REGS-1).
Ports (name  direction  width  meaning):
REQ-004 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have reg_write  input  1  write enable.
REQ-007 SHALL have read_reg1  input  ADDR_WIDTH  read port 1 address.
REQ-008 SHALL have read_reg2  input  ADDR_WIDTH  read port 2 address.
REQ-009 SHALL have write_reg  input  ADDR_WIDTH  write port address.
REQ-010 SHALL have write_data  input  DATA_WIDTH  write port data.
REQ-011 SHALL have read_data1  output  DATA_WIDTH  contents of register read_reg1.
REQ-012 SHALL have read_data2  output  DATA_WIDTH  contents of register read_reg2.

Function
REQ-013 SHALL hold NUM_REGS registers of DATA_WIDTH bits; two independent read ports, one write port.
REQ-014 SHALL, on rising clk with reg_write=1 and write_reg!=0, store write_data into register write_reg.
REQ-015 SHALL ignore writes with reg_write=0; no register changes.
REQ-016 SHALL ignore writes to x0 (write_reg=0) even with reg_write=1; x0 storage never changes.
REQ-017 SHALL drive read_data1/read_data2 combinationally from read_reg1/read_reg2: zero-cycle latency, no clock needed to read.
REQ-018 SHALL return 0 on any read port addressing x0, regardless of any write attempt.
REQ-019 SHALL, when reading a register written at the previous rising edge, return the new value immediately after that edge.
REQ-020 SHALL provide write-through bypass: if reg_write=1, write_reg!=0 and a read address equals write_reg, that read port SHALL output write_data in the same cycle, before the edge.
REQ-021 SHALL allow both read ports to address the same register simultaneously, both returning identical data.
REQ-022 SHALL keep register contents unchanged between writes; no other side effects.
REQ-023 SHALL produce no X on outputs after reset for any in-range address.

Reset
REQ-024 SHALL clear all registers to 0 immediately when rst_n goes low, independent of clk.
REQ-025 SHALL block writes while rst_n=0; read outputs SHALL be 0 during reset.
REQ-026 SHALL resume normal writes at the first rising clk after rst_n returns high.
REQ-027 SHALL, on reset asserted mid-operation, discard all previously written values; post-reset reads return 0.

Verification
REQ-028 Write x1: reg_write=1, write_reg=1, write_data=A5A5A5A5, one edge; then reg_write=0, read_reg1=1, read_reg2=0 -> read_data1=A5A5A5A5, read_data2=00000000.
REQ-029 Write x2=12345678, then read_reg1=2, read_reg2=1 -> read_data1=12345678, read_data2=A5A5A5A5 (x1 retained).
REQ-030 Write x0: reg_write=1, write_reg=0, write_data=FFFFFFFF, one edge; read_reg1=0 -> read_data1=00000000.
REQ-031 reg_write=0, write_reg=3, write_data=DEADBEEF, one edge; read_reg1=3 -> 00000000.
REQ-032 Bypass: reg_write=1, write_reg=5, write_data=CAFEF00D, read_reg2=5 before edge -> read_data2=CAFEF00D immediately.
REQ-033 After writing x1 and x2, pulse rst_n low between edges -> read_data1/read_data2 drop to 00000000 at once; reads of x1, x2 after release return 00000000.

Source files
------------

// File: rtl/register_file.sv
// Two-read, one-write register file with hardwired-zero x0 and write-through bypass.
// Reads are combinational; all stored state clears asynchronously on rst_n low.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = NUM_REGS[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_write_en;
  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];

  // A write only counts when it targets an existing, non-zero register.
  assign w_write_en = reg_write && (write_reg != '0) && ({1'b0, write_reg} < LP_NUM_REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  assign w_raddr[0] = read_reg1;
  assign w_raddr[1] = read_reg2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      // Reset gates the bypass too, so outputs stay zero while rst_n is low.
      always_comb begin
        w_rdata[gi] = '0;
        if (rst_n && (w_raddr[gi] != '0) && ({1'b0, w_raddr[gi]} < LP_NUM_REGS)) begin
          if (w_write_en && (w_raddr[gi] == write_reg)) begin
            w_rdata[gi] = write_data;
          end else begin
            w_rdata[gi] = r_regs[w_raddr[gi]];
          end
        end
      end
    end
  endgenerate

  assign read_data1 = w_rdata[0];
  assign read_data2 = w_rdata[1];

endmodule

// File: tb/tb_register_file.sv
// Directed-vector bench for register_file: writes, x0 protection, bypass and async reset.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int n_vec;
  int n_miss;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic do_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    read_reg1 = a1;
    read_reg2 = a2;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    reg_write = 1'b1;
    write_reg = 5'd1;
    write_data = 32'h1111_1111;
    read_reg1 = 5'd1;
    read_reg2 = 5'd1;
    @(posedge clk);
    #1;
    // Bypass must be suppressed and writes blocked during reset.
    check_vec("reset_rd1", read_data1, 32'h0);
    check_vec("reset_rd2", read_data2, 32'h0);
    reg_write = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_reads(5'd1, 5'd1);
    check_vec("post_reset_x1", read_data1, 32'h0);

    do_edge(1'b1, 5'd1, 32'hA5A5_A5A5);
    set_reads(5'd1, 5'd0);
    check_vec("x1_write_rd1", read_data1, 32'hA5A5_A5A5);
    check_vec("x0_rd2", read_data2, 32'h0);

    do_edge(1'b1, 5'd2, 32'h1234_5678);
    set_reads(5'd2, 5'd1);
    check_vec("x2_write_rd1", read_data1, 32'h1234_5678);
    check_vec("x1_retained_rd2", read_data2, 32'hA5A5_A5A5);

    do_edge(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_reads(5'd0, 5'd0);
    check_vec("x0_write_ignored", read_data1, 32'h0);

    do_edge(1'b0, 5'd3, 32'hDEAD_BEEF);
    set_reads(5'd3, 5'd2);
    check_vec("we0_ignored", read_data1, 32'h0);
    check_vec("we0_x2_kept", read_data2, 32'h1234_5678);

    // Bypass before the edge on port 2, then on port 1.
    set_reads(5'd1, 5'd5);
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hCAFE_F00D;
    #1;
    check_vec("bypass_rd2", read_data2, 32'hCAFE_F00D);
    check_vec("bypass_rd1_other", read_data1, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    check_vec("x5_stored", read_data2, 32'hCAFE_F00D);

    set_reads(5'd6, 5'd6);
    reg_write = 1'b1; write_reg = 5'd6; write_data = 32'h0BAD_CAFE;
    #1;
    check_vec("bypass_rd1", read_data1, 32'h0BAD_CAFE);
    reg_write = 1'b0;
    #1;
    check_vec("bypass_we0_off", read_data1, 32'h0);

    // x0 bypass must never happen.
    set_reads(5'd0, 5'd0);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h5555_AAAA;
    #1;
    check_vec("bypass_x0_blocked", read_data1, 32'h0);
    reg_write = 1'b0;

    do_edge(1'b1, 5'd31, 32'h8000_0001);
    set_reads(5'd31, 5'd31);
    check_vec("x31_rd1", read_data1, 32'h8000_0001);
    check_vec("x31_rd2_same", read_data2, 32'h8000_0001);

    do_edge(1'b1, 5'd2, 32'h0000_FFFF);
    set_reads(5'd2, 5'd1);
    check_vec("x2_overwrite", read_data1, 32'h0000_FFFF);

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_vec("async_rst_rd1", read_data1, 32'h0);
    check_vec("async_rst_rd2", read_data2, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    set_reads(5'd1, 5'd2);
    check_vec("rst_cleared_x1", read_data1, 32'h0);
    check_vec("rst_cleared_x2", read_data2, 32'h0);
    set_reads(5'd31, 5'd5);
    check_vec("rst_cleared_x31", read_data1, 32'h0);
    check_vec("rst_cleared_x5", read_data2, 32'h0);

    do_edge(1'b1, 5'd4, 32'h600D_F00D);
    set_reads(5'd4, 5'd1);
    check_vec("resume_x4", read_data1, 32'h600D_F00D);
    check_vec("resume_x1_zero", read_data2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
